// File: rtl/rt_pkg.sv
// Shared constants for the reaction timer: FSM state codes, LFSR seed,
// feedback taps and the LFSR step function.
package rt_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_TIME    = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_FALSE   = 3'd4;
   localparam logic [2:0] S_TIMEOUT = 3'd5;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // taps 16,14,13,11 -> bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rt_bcd_counter.sv
// Cascaded NDIG-digit BCD up-counter.
//   clk       : clock
//   clr       : synchronous clear to zero (has priority over inc)
//   inc       : add one with decimal carry across all digits
//   value     : digit i at [4i+3:4i], digit 0 least significant
//   all_nines : every digit is 9
module rt_bcd_counter #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              inc,
   output logic [4*NDIG-1:0] value,
   output logic              all_nines
);

   logic [4*NDIG-1:0] value_nxt;
   logic              carry;

   always_comb begin
      value_nxt = value;
      carry     = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (carry) begin
            if (value[4*i +: 4] == 4'd9) begin
               value_nxt[4*i +: 4] = 4'd0;
            end else begin
               value_nxt[4*i +: 4] = value[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   always_comb begin
      all_nines = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (value[4*i +: 4] != 4'd9) all_nines = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr)      value <= '0;
      else if (inc) value <= value_nxt;
   end

endmodule

// File: rtl/reaction_timer_gen.sv
// Reaction timer: random wait, lamp on, count ms until the press, keep best.
//   clk, reset(active-low, synchronous)
//   start/stop/clear : one-cycle debounced requests
//   show_best        : level, selects best time onto bcd
//   led              : stimulus lamp, high only while timing
//   bcd              : 4*NDIG bits, digit 0 = ms units
//   state            : current state code
//   done_tick        : one-cycle pulse on entry to DONE
//   err_early        : high in FALSE,  err_timeout : high in TIMEOUT
//   best_valid       : at least one valid result recorded
//
// state   | meaning
// IDLE    | waiting for start
// WAIT    | random delay running, lamp off
// TIME    | lamp on, counting ms
// DONE    | valid reaction captured
// FALSE   | stop pressed before the lamp
// TIMEOUT | counter saturated at all 9s
module reaction_timer_gen
   import rt_pkg::*;
#(
   parameter int TICK_DIV     = 50000,
   parameter int NDIG         = 4,
   parameter int DELAY_MIN_MS = 1000,
   parameter int DLY_BITS     = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              show_best,
   output logic              led,
   output logic [4*NDIG-1:0] bcd,
   output logic [2:0]        state,
   output logic              done_tick,
   output logic              err_early,
   output logic              err_timeout,
   output logic              best_valid
);

   localparam int DW = $clog2(DELAY_MIN_MS + (1 << DLY_BITS)) + 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);

   logic [2:0]        state_nxt;
   logic [PW-1:0]     presc;
   logic [DW-1:0]     delay;
   logic [15:0]       lfsr;
   logic [4*NDIG-1:0] counter;
   logic [4*NDIG-1:0] best;
   logic              all_nines;
   logic              timing;
   logic              ms_tick;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              enter_done;

   assign timing  = (state == S_WAIT) || (state == S_TIME);
   assign ms_tick = timing && (presc == '0);

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT: begin
               if (stop)                                 state_nxt = S_FALSE;
               else if (ms_tick && (delay <= DW'(1)))   state_nxt = S_TIME;
            end
            S_TIME: begin
               if (stop)                      state_nxt = S_DONE;
               else if (ms_tick && all_nines) state_nxt = S_TIMEOUT;
            end
            S_DONE, S_FALSE, S_TIMEOUT: state_nxt = state;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign enter_done = (state == S_TIME) && (state_nxt == S_DONE);
   assign cnt_clr    = !reset || clear || ((state == S_IDLE) && start);
   assign cnt_inc    = (state == S_TIME) && ms_tick && !stop && !clear && !all_nines;

   rt_bcd_counter #(.NDIG(NDIG)) u_cnt (
      .clk       (clk),
      .clr       (cnt_clr),
      .inc       (cnt_inc),
      .value     (counter),
      .all_nines (all_nines)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         presc      <= '0;
         delay      <= '0;
         lfsr       <= LFSR_SEED;
         best       <= '0;
         best_valid <= 1'b0;
         done_tick  <= 1'b0;
      end else begin
         state     <= state_nxt;
         lfsr      <= lfsr_next(lfsr);
         done_tick <= enter_done;

         // reload on any state change so WAIT and TIME both start a full ms
         if ((state_nxt != state) || !timing || (presc == '0)) presc <= PRESC_LOAD;
         else                                                  presc <= presc - PW'(1);

         if ((state == S_IDLE) && start && !clear)
            delay <= DW'(DELAY_MIN_MS) + DW'(lfsr[DLY_BITS-1:0]);
         else if ((state == S_WAIT) && ms_tick)
            delay <= delay - DW'(1);

         // packed BCD with digits 0..9 orders the same as a plain unsigned
         // compare, i.e. most significant digit first
         if (enter_done) begin
            if (!best_valid || (counter < best)) best <= counter;
            best_valid <= 1'b1;
         end
      end
   end

   assign led         = (state == S_TIME);
   assign err_early   = (state == S_FALSE);
   assign err_timeout = (state == S_TIMEOUT);
   assign bcd         = show_best ? best : counter;

endmodule

// File: tb/tb_reaction_timer_gen.sv
module tb_reaction_timer_gen;

   localparam logic [2:0] T_IDLE = 3'd0, T_WAIT = 3'd1, T_TIME = 3'd2,
                          T_DONE = 3'd3, T_FALSE = 3'd4, T_TOUT = 3'd5;

   typedef struct packed {
      logic [2:0]  st;
      logic [11:0] val;
      logic        led;
      logic        ee;
      logic        et;
      logic        dt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, start, stop, clear, show_best;
   logic        led, done_tick, err_early, err_timeout, best_valid;
   logic [11:0] bcd;
   logic [2:0]  state;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   logic        mon_en = 1'b0;
   logic        led_seen = 1'b0;
   logic        prev_dt = 1'b0;
   logic [2:0]  last_state;

   reaction_timer_gen #(
      .TICK_DIV(4), .NDIG(3), .DELAY_MIN_MS(2), .DLY_BITS(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .show_best(show_best), .led(led), .bcd(bcd), .state(state),
      .done_tick(done_tick), .err_early(err_early), .err_timeout(err_timeout),
      .best_valid(best_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] st, input logic [11:0] v,
                               input logic l, input logic ee, input logic et, input logic dt);
      exp_t e;
      e.st = st; e.val = v; e.led = l; e.ee = ee; e.et = et; e.dt = dt;
      return e;
   endfunction

   task automatic drive(input logic s, input logic p, input logic c);
      start = s; stop = p; clear = c;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int bound, input string nm);
      int n = 0;
      while (state !== s && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {29'd0, state}, {29'd0, s});
   endtask

   task automatic wait_bcd(input logic [11:0] v, input int bound, input string nm);
      int n = 0;
      while (bcd !== v && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {20'd0, bcd}, {20'd0, v});
   endtask

   task automatic check_best(input logic [11:0] v);
      show_best = 1'b1;
      #1;
      chk("best_value", {20'd0, bcd}, {20'd0, v});
      chk("best_valid", {31'd0, best_valid}, 32'd1);
      show_best = 1'b0;
      #1;
   endtask

   task automatic run_to(input logic do_clear, input logic [11:0] v);
      if (do_clear) begin
         q.push_back(mk(T_IDLE, 12'h000, 0, 0, 0, 0));
         drive(0, 0, 1);
         drive(0, 1, 0);
      end
      q.push_back(mk(T_WAIT, 12'h000, 0, 0, 0, 0));
      q.push_back(mk(T_TIME, 12'h000, 1, 0, 0, 0));
      drive(1, 0, 0);
      wait_state(T_TIME, 200, "led_rise");
      wait_bcd(v, 4 * 1000, "count_reach");
      q.push_back(mk(T_DONE, v, 0, 0, 0, 1));
      drive(0, 1, 0);
      repeat (2) @(negedge clk);
   endtask

   // monitor: pops one expected record on every state change
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (done_tick) done_cnt++;
            if (prev_dt) chk("done_tick_width", {31'd0, done_tick}, 32'd0);
            prev_dt = done_tick;
            if (led) led_seen = 1'b1;
            if (state !== last_state) begin
               if (q.size() == 0) begin
                  chk("unexpected_transition", {29'd0, state}, {29'd0, last_state});
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("transition", {13'd0, state, bcd, led, err_early, err_timeout, done_tick},
                      {13'd0, e});
               end
               last_state = state;
            end
         end
      end
   end

   initial begin
      reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; show_best = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_led", {31'd0, led}, 32'd0);
      chk("rst_bcd", {20'd0, bcd}, 32'd0);
      chk("rst_best_valid", {31'd0, best_valid}, 32'd0);
      chk("rst_done_tick", {31'd0, done_tick}, 32'd0);
      chk("rst_errs", {30'd0, err_early, err_timeout}, 32'd0);
      reset = 1'b1;
      last_state = state;
      mon_en = 1'b1;
      @(negedge clk);

      // run 1: 037 ms, first result always becomes best
      run_to(1'b0, 12'h037);
      check_best(12'h037);
      drive(1, 1, 0);
      @(negedge clk);
      chk("done_hold_state", {29'd0, state}, {29'd0, T_DONE});
      chk("done_hold_bcd", {20'd0, bcd}, 32'h037);

      // run 2 slower, run 3 faster
      run_to(1'b1, 12'h052);
      chk("run2_counter", {20'd0, bcd}, 32'h052);
      check_best(12'h037);
      run_to(1'b1, 12'h021);
      check_best(12'h021);

      // false start
      q.push_back(mk(T_IDLE, 12'h000, 0, 0, 0, 0));
      drive(0, 0, 1);
      led_seen = 1'b0;
      q.push_back(mk(T_WAIT, 12'h000, 0, 0, 0, 0));
      drive(1, 0, 0);
      @(negedge clk);
      q.push_back(mk(T_FALSE, 12'h000, 0, 1, 0, 0));
      drive(0, 1, 0);
      @(negedge clk);
      chk("false_err_early", {31'd0, err_early}, 32'd1);
      chk("false_led_seen", {31'd0, led_seen}, 32'd0);
      check_best(12'h021);
      drive(1, 1, 0);
      @(negedge clk);
      chk("false_hold_state", {29'd0, state}, {29'd0, T_FALSE});

      // timeout after 1000 ms
      q.push_back(mk(T_IDLE, 12'h000, 0, 0, 0, 0));
      drive(0, 0, 1);
      q.push_back(mk(T_WAIT, 12'h000, 0, 0, 0, 0));
      q.push_back(mk(T_TIME, 12'h000, 1, 0, 0, 0));
      drive(1, 0, 0);
      wait_state(T_TIME, 200, "tout_led_rise");
      q.push_back(mk(T_TOUT, 12'h999, 0, 0, 1, 0));
      wait_state(T_TOUT, 4200, "tout_reach");
      repeat (8) @(negedge clk);
      chk("tout_bcd_hold", {20'd0, bcd}, 32'h999);
      chk("tout_err", {31'd0, err_timeout}, 32'd1);
      drive(1, 1, 0);
      @(negedge clk);
      chk("tout_hold_state", {29'd0, state}, {29'd0, T_TOUT});
      check_best(12'h021);

      // stop coincident with a ms tick at 014
      q.push_back(mk(T_IDLE, 12'h000, 0, 0, 0, 0));
      drive(0, 0, 1);
      q.push_back(mk(T_WAIT, 12'h000, 0, 0, 0, 0));
      q.push_back(mk(T_TIME, 12'h000, 1, 0, 0, 0));
      drive(1, 0, 0);
      wait_state(T_TIME, 200, "coin_led_rise");
      wait_bcd(12'h014, 200, "coin_reach");
      repeat (3) @(negedge clk);
      q.push_back(mk(T_DONE, 12'h014, 0, 0, 0, 1));
      drive(0, 1, 0);
      @(negedge clk);
      chk("coin_counter", {20'd0, bcd}, 32'h014);
      check_best(12'h014);
      q.push_back(mk(T_IDLE, 12'h000, 0, 0, 0, 0));
      drive(1, 1, 1);
      repeat (3) @(negedge clk);
      chk("clear_wins_state", {29'd0, state}, {29'd0, T_IDLE});

      // reset while timing at 300
      q.push_back(mk(T_WAIT, 12'h000, 0, 0, 0, 0));
      q.push_back(mk(T_TIME, 12'h000, 1, 0, 0, 0));
      drive(1, 0, 0);
      wait_state(T_TIME, 200, "r300_led_rise");
      wait_bcd(12'h300, 1400, "r300_reach");
      q.push_back(mk(T_IDLE, 12'h000, 0, 0, 0, 0));
      reset = 1'b0;
      @(negedge clk);
      chk("r300_state", {29'd0, state}, 32'd0);
      chk("r300_led", {31'd0, led}, 32'd0);
      chk("r300_bcd", {20'd0, bcd}, 32'd0);
      chk("r300_best_valid", {31'd0, best_valid}, 32'd0);
      chk("r300_done_tick", {31'd0, done_tick}, 32'd0);
      show_best = 1'b1;
      #1;
      chk("r300_best", {20'd0, bcd}, 32'd0);
      show_best = 1'b0;
      reset = 1'b1;
      repeat (4) @(negedge clk);

      chk("queue_empty", q.size(), 32'd0);
      chk("done_tick_count", done_cnt, 32'd4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reaction_timer_gen.md
REACTION_TIMER_GEN -- requirements
Module: reaction_timer_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per 1 ms tick.
REQ-002 SHALL have parameter NDIG, default 4, BCD digits of the reaction counter (range 1..6).
REQ-003 SHALL have parameter DELAY_MIN_MS, default 1000, minimum random wait in ms.
REQ-004 SHALL have parameter DLY_BITS, default 11, LFSR bits added to the wait, giving 0..2^DLY_BITS-1 ms.
REQ-005 SHALL have ports: clk  in  1  sole clock; one clock domain, rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports: start  in  1  one-cycle, debounced start request.
REQ-008 SHALL have ports: stop  in  1  one-cycle, debounced reaction press.
REQ-009 SHALL have ports: clear  in  1  one-cycle return to IDLE; best time kept.
REQ-010 SHALL have ports: show_best  in  1  level; 1 drives the best time onto bcd.
REQ-011 SHALL have ports: led  out  1  stimulus lamp; 1 only in TIME.
REQ-012 SHALL have ports: bcd  out  4*NDIG  digit i at [4i+3:4i]; digit 0 is ms units.
REQ-013 SHALL have ports: state  out  3  current state code.
REQ-014 SHALL have ports: done_tick  out  1  one-cycle pulse on entry to DONE.
REQ-015 SHALL have ports: err_early / err_timeout  out  1 each  levels, high in FALSE / TIMEOUT.
REQ-016 SHALL have ports: best_valid  out  1  at least one valid result recorded.

Function
REQ-017 SHALL have states IDLE=0, WAIT=1, TIME=2, DONE=3, FALSE=4, TIMEOUT=5, all registered.
REQ-018 IDLE: start -> WAIT; counter zeroed; delay = DELAY_MIN_MS + lfsr[DLY_BITS-1:0] latched the same cycle.
REQ-019 WAIT: ms prescaler restarts on entry; delay decrements per ms tick; tick at delay==1 -> TIME next cycle.
REQ-020 WAIT: stop -> FALSE (false start), counter stays 0, err_early=1.
REQ-021 TIME: led=1, prescaler restarted on entry, BCD counter +1 per ms tick with decimal carry across NDIG digits.
REQ-022 TIME: stop -> DONE next cycle; stop wins over a coincident ms tick (that tick not counted); done_tick=1 for one cycle.
REQ-023 TIME: ms tick with counter all 9s -> TIMEOUT, counter holds all 9s, no wrap to 0.
REQ-024 DONE/FALSE/TIMEOUT: hold counter; start and stop ignored; only clear leaves.
REQ-025 Clear in any state -> IDLE next cycle, counter zeroed; clear wins over coincident start and stop.
REQ-026 Stop in IDLE ignored; start in WAIT/TIME ignored.
REQ-027 Entry to DONE: best <= counter if !best_valid or counter < best (BCD compare, MSD first), and best_valid <= 1; equal value unchanged.
REQ-028 bcd = show_best ? best : counter, combinational mux of registered values.
REQ-029 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle, never all-zero.

Reset
REQ-030 On clk edge with reset=0: state IDLE, led 0, counter 0, best 0, best_valid 0, done_tick 0, err flags 0, prescaler 0, lfsr 16'hACE1.
REQ-031 Reset mid-WAIT or mid-TIME SHALL abort without a done_tick or best update.

Structure
REQ-032 Package rt_pkg SHALL hold the state enum/codes, LFSR seed and tap constants.
REQ-033 Sub-module rt_bcd_counter (NDIG parameter; clr, inc, value, all_nines) SHALL implement the cascaded BCD counter.
REQ-034 Prescaler, wait counter, LFSR and FSM SHALL stay in the top module.

Verification (TICK_DIV=4, NDIG=3, DELAY_MIN_MS=2, DLY_BITS=2)
REQ-035 Reset, start, stop 37 ms after led rises -> bcd=037, done_tick one cycle, best=037, best_valid=1.
REQ-036 Second run stopped at 052 ms -> counter 052, best stays 037; third at 021 ms -> best=021.
REQ-037 Stop during WAIT -> state FALSE, err_early=1, led never 1, best unchanged.
REQ-038 No stop for 1000 ms tick periods -> TIMEOUT, bcd=999, err_timeout=1, no done_tick.
REQ-039 Stop and ms tick in the same cycle at count 014 -> DONE with 014; clear with start together -> IDLE.
REQ-040 reset=0 in TIME at count 300 -> all outputs at reset values next edge, best_valid=0.
